// File: rtl/ov9281_init_seq_pkg.sv
// ov9281_init_seq_pkg
//   Shared types and the power-up register table for the OV9281 init sequencer.
//   - op_t / cfg_entry_t : one table entry {op, addr, data}; for OP_DELAY the
//     addr field carries the delay in milliseconds.
//   - seq_state_t        : sequencer FSM states. The readback states exist only
//     when OV9281_INIT_VERIFY_EN is defined.
//   - INIT_TABLE         : sensor init table. Indices past its end read as OP_END.
package ov9281_init_seq_pkg;

   typedef enum logic [1:0] {
      OP_WRITE = 2'd0,
      OP_DELAY = 2'd1,
      OP_END   = 2'd2
   } op_t;

   typedef struct packed {
      op_t         op;
      logic [15:0] addr;
      logic [7:0]  data;
   } cfg_entry_t;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_ISSUE,
      ST_WAIT,
      ST_DELAY,
      ST_DONE,
      ST_FAIL
`ifdef OV9281_INIT_VERIFY_EN
      , ST_RD_ISSUE,
      ST_RD_WAIT
`endif
   } seq_state_t;

   localparam int INIT_LEN = 4;
   localparam int INIT_IW  = $clog2(INIT_LEN);

   // Software reset, let the sensor settle, then start streaming.
   localparam cfg_entry_t INIT_TABLE [INIT_LEN] = '{
      '{OP_WRITE, 16'h0103, 8'h01},
      '{OP_DELAY, 16'd10,   8'h00},
      '{OP_WRITE, 16'h0100, 8'h01},
      '{OP_END,   16'h0000, 8'h00}
   };

   function automatic cfg_entry_t init_entry(input int unsigned i);
      if (i < INIT_LEN) return INIT_TABLE[INIT_IW'(i)];
      return '{OP_END, 16'h0000, 8'h00};
   endfunction

endpackage

// File: rtl/ov9281_init_seq_rom.sv
// ov9281_init_seq_rom
//   Registered lookup of the init table, one cycle latency.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     idx        : table index
//     entry      : entry[idx], registered
module ov9281_init_seq_rom
   import ov9281_init_seq_pkg::*;
#(
   parameter int TABLE_DEPTH = 64,
   parameter int IDX_W       = $clog2(TABLE_DEPTH)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] idx,
   output cfg_entry_t       entry
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) entry <= '0;
      else        entry <= init_entry(32'(idx));
   end

endmodule

// File: rtl/ov9281_init_seq.sv
// ov9281_init_seq
//   Power-up register sequencer for the OV9281. Walks the init table, issues
//   register writes to ov9281_cfg, executes millisecond delays, retries failed
//   writes up to MAX_RETRY attempts and reports done/fail.
//   Optional macro OV9281_INIT_VERIFY_EN: every completed write is read back
//   and compared; a mismatch costs one retry and re-runs the write.
//   Ports:
//     i_clk, i_rst_n      : clock, asynchronous active-low reset
//     i_start             : 1-cycle pulse, run table from index 0 (IDLE/DONE/FAIL only)
//     o_busy/o_done/o_fail: status levels; o_fail_idx = failing table index
//     o_cfg_start         : 1-cycle request strobe to ov9281_cfg
//     o_cfg_write/_read   : request type, held with o_cfg_addr/o_cfg_wdata
//     i_cfg_busy          : cfg unit busy, strobe only while low
//     i_cfg_valid/_error  : 1-cycle completion / failure (error wins)
//     i_cfg_rdata         : readback data (verify build only)
module ov9281_init_seq
   import ov9281_init_seq_pkg::*;
#(
   parameter  int CLK_FREQ       = 50000000,
   parameter  int REG_ADDR_WIDTH = 16,
   parameter  int REG_DATA_WIDTH = 8,
   parameter  int TABLE_DEPTH    = 64,
   parameter  int MAX_RETRY      = 3,
   parameter  int TIMEOUT_CYC    = 1000000,
   localparam int IDX_W          = $clog2(TABLE_DEPTH)
)(
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_fail,
   output logic [IDX_W-1:0]          o_fail_idx,
   output logic                      o_cfg_start,
   output logic                      o_cfg_write,
   output logic                      o_cfg_read,
   output logic [REG_ADDR_WIDTH-1:0] o_cfg_addr,
   output logic [REG_DATA_WIDTH-1:0] o_cfg_wdata,
   input  logic                      i_cfg_busy,
   input  logic                      i_cfg_valid,
   input  logic                      i_cfg_error,
   input  logic [REG_DATA_WIDTH-1:0] i_cfg_rdata
);

   localparam int CYC_PER_MS = CLK_FREQ / 1000;
   // Longest delay is 65535 ms; computed in 64 bits so 50 MHz does not overflow.
   localparam longint unsigned DLY_MAX = 64'd65535 * 64'(CYC_PER_MS);
   localparam int DLY_W = $clog2(DLY_MAX + 64'd1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);

   seq_state_t       state;
   cfg_entry_t       entry;
   logic [IDX_W-1:0] idx;
   logic [RTY_W-1:0] retry;
   logic [TMO_W-1:0] tmo_cnt;
   logic [DLY_W-1:0] dly_cnt;
   logic             last_idx, in_wait, tmo_hit, rd_bad, att_bad, att_ok;

   ov9281_init_seq_rom #(.TABLE_DEPTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_rom (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .idx   (idx),
      .entry (entry)
   );

`ifdef OV9281_INIT_VERIFY_EN
   logic cfg_read_q;
   assign o_cfg_read = cfg_read_q;
   assign in_wait    = (state == ST_WAIT) || (state == ST_RD_WAIT);
   assign rd_bad     = (state == ST_RD_WAIT) && i_cfg_valid && (i_cfg_rdata != o_cfg_wdata);
`else
   logic unused_rdata;
   assign unused_rdata = ^i_cfg_rdata;
   assign o_cfg_read   = 1'b0;
   assign in_wait      = (state == ST_WAIT);
   assign rd_bad       = 1'b0;
`endif

   assign last_idx = (idx == IDX_W'(TABLE_DEPTH - 1));
   assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   // A failed attempt takes priority over a simultaneous valid.
   assign att_bad  = in_wait && (i_cfg_error || tmo_hit || rd_bad);
   assign att_ok   = in_wait && i_cfg_valid;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         retry       <= '0;
         tmo_cnt     <= '0;
         dly_cnt     <= '0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_fail      <= 1'b0;
         o_fail_idx  <= '0;
         o_cfg_start <= 1'b0;
         o_cfg_write <= 1'b0;
         o_cfg_addr  <= '0;
         o_cfg_wdata <= '0;
`ifdef OV9281_INIT_VERIFY_EN
         cfg_read_q  <= 1'b0;
`endif
      end else begin
         o_cfg_start <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE, ST_FAIL: begin
               if (i_start) begin
                  o_done     <= 1'b0;
                  o_fail     <= 1'b0;
                  o_fail_idx <= '0;
                  idx        <= '0;
                  retry      <= '0;
                  o_busy     <= 1'b1;
                  state      <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               o_cfg_addr  <= REG_ADDR_WIDTH'(entry.addr);
               o_cfg_wdata <= REG_DATA_WIDTH'(entry.data);
               o_cfg_write <= 1'b0;
`ifdef OV9281_INIT_VERIFY_EN
               cfg_read_q  <= 1'b0;
`endif
               case (entry.op)
                  OP_WRITE: begin
                     // Strobe straight from DECODE so the first request lands
                     // two cycles after start.
                     if (!i_cfg_busy) begin
                        o_cfg_start <= 1'b1;
                        o_cfg_write <= 1'b1;
                        tmo_cnt     <= '0;
                        state       <= ST_WAIT;
                     end else begin
                        state <= ST_ISSUE;
                     end
                  end
                  OP_DELAY: begin
                     dly_cnt <= DLY_W'(entry.addr) * DLY_W'(CYC_PER_MS);
                     state   <= ST_DELAY;
                  end
                  default: begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_DONE;
                  end
               endcase
            end
            ST_ISSUE: begin
               if (!i_cfg_busy) begin
                  o_cfg_start <= 1'b1;
                  o_cfg_write <= 1'b1;
`ifdef OV9281_INIT_VERIFY_EN
                  cfg_read_q  <= 1'b0;
`endif
                  tmo_cnt     <= '0;
                  state       <= ST_WAIT;
               end
            end
`ifdef OV9281_INIT_VERIFY_EN
            ST_RD_ISSUE: begin
               if (!i_cfg_busy) begin
                  o_cfg_start <= 1'b1;
                  o_cfg_write <= 1'b0;
                  cfg_read_q  <= 1'b1;
                  tmo_cnt     <= '0;
                  state       <= ST_RD_WAIT;
               end
            end
            ST_WAIT, ST_RD_WAIT: begin
`else
            ST_WAIT: begin
`endif
               if (att_bad) begin
                  if (retry == RTY_W'(MAX_RETRY - 1)) begin
                     o_fail     <= 1'b1;
                     o_fail_idx <= idx;
                     o_busy     <= 1'b0;
                     state      <= ST_FAIL;
                  end else begin
                     retry <= retry + 1'b1;
                     state <= ST_ISSUE;
                  end
`ifdef OV9281_INIT_VERIFY_EN
               end else if (att_ok && state == ST_WAIT) begin
                  state <= ST_RD_ISSUE;
`endif
               end else if (att_ok) begin
                  if (last_idx) begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     retry <= '0;
                     state <= ST_FETCH;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DELAY: begin
               if (dly_cnt == '0) begin
                  if (last_idx) begin
                     o_done <= 1'b1;
                     o_busy <= 1'b0;
                     state  <= ST_DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     retry <= '0;
                     state <= ST_FETCH;
                  end
               end else begin
                  dly_cnt <= dly_cnt - 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ov9281_init_seq.sv
// tb_ov9281_init_seq
//   Bench for ov9281_init_seq with a small ov9281_cfg model. Expected strobes
//   are queued when a run is started and popped as the DUT issues them.
//   Table: {W 0x0103=0x01, D 10, W 0x0100=0x01, END}; CYC_PER_MS = 10.
module tb_ov9281_init_seq;

`ifdef OV9281_INIT_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0;
   logic        i_cfg_busy = 1'b0, i_cfg_valid = 1'b0, i_cfg_error = 1'b0;
   logic [7:0]  i_cfg_rdata = 8'h00;
   logic        o_busy, o_done, o_fail, o_cfg_start, o_cfg_write, o_cfg_read;
   logic [5:0]  o_fail_idx;
   logic [15:0] o_cfg_addr;
   logic [7:0]  o_cfg_wdata;

   ov9281_init_seq #(
      .CLK_FREQ(10000), .REG_ADDR_WIDTH(16), .REG_DATA_WIDTH(8),
      .TABLE_DEPTH(64), .MAX_RETRY(3), .TIMEOUT_CYC(100)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail), .o_fail_idx(o_fail_idx),
      .o_cfg_start(o_cfg_start), .o_cfg_write(o_cfg_write), .o_cfg_read(o_cfg_read),
      .o_cfg_addr(o_cfg_addr), .o_cfg_wdata(o_cfg_wdata),
      .i_cfg_busy(i_cfg_busy), .i_cfg_valid(i_cfg_valid), .i_cfg_error(i_cfg_error),
      .i_cfg_rdata(i_cfg_rdata)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   typedef struct packed {
      logic        rd;
      logic [15:0] addr;
      logic [7:0]  data;
   } stb_t;

   stb_t exp_q[$];
   int   stb_cyc[$];

   // cfg model knobs
   logic [15:0] err_addr = 16'hFFFF;
   int          err_left = 0;        // -1: error forever
   bit          noresp = 1'b0;       // never answer writes to err_addr
   bit          bad_rd_once = 1'b0;  // first readback of 0x0100 returns 0x00
   int          resp_cnt = 0;
   bit          resp_err = 1'b0;
   logic [7:0]  resp_rdata = 8'h00;

   always begin : cfg_model
      stb_t got, e;
      @(posedge i_clk); #1;
      i_cfg_valid = 1'b0;
      i_cfg_error = 1'b0;
      if (!i_rst_n) begin
         resp_cnt = 0;
      end else begin
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               if (resp_err) i_cfg_error = 1'b1;
               else begin
                  i_cfg_valid = 1'b1;
                  i_cfg_rdata = resp_rdata;
               end
            end
         end
         if (o_cfg_start) begin
            got = {o_cfg_read, o_cfg_addr, o_cfg_wdata};
            stb_cyc.push_back(cyc);
            chk("strobe_wr_flag", o_cfg_write, !o_cfg_read);
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL strobe_extra: unexpected strobe rd=%0b addr 0x%0h data 0x%0h",
                        o_cfg_read, o_cfg_addr, o_cfg_wdata);
            end else begin
               e = exp_q.pop_front();
               chk("strobe_rd_addr_data", got, e);
            end
            if (!(noresp && !o_cfg_read && o_cfg_addr == err_addr)) begin
               resp_cnt   = 20;
               resp_err   = !o_cfg_read && (o_cfg_addr == err_addr) && (err_left != 0);
               if (resp_err && err_left > 0) err_left--;
               resp_rdata = 8'h01;
               if (o_cfg_read && o_cfg_addr == 16'h0100 && bad_rd_once) begin
                  resp_rdata  = 8'h00;
                  bad_rd_once = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge i_clk); #1;
      end
   endtask

   task automatic push(input bit rd, input logic [15:0] a);
      exp_q.push_back({rd, a, 8'h01});
   endtask

   // A write that completes is followed by its readback in the verify build.
   task automatic push_w(input logic [15:0] a, input bit ok);
      push(1'b0, a);
      if (VER && ok) push(1'b1, a);
   endtask

   task automatic push_normal();
      push_w(16'h0103, 1'b1);
      push_w(16'h0100, 1'b1);
   endtask

   task automatic clear_model();
      exp_q.delete();
      stb_cyc.delete();
      err_addr    = 16'hFFFF;
      err_left    = 0;
      noresp      = 1'b0;
      bad_rd_once = 1'b0;
   endtask

   task automatic start_pulse();
      i_start = 1'b1;
      tick(1);
      i_start = 1'b0;
   endtask

   task automatic wait_end(input string nm, input int budget);
      bit hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         tick(1);
         hit = o_done || o_fail;
      end
      if (!hit) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s_wait: no done/fail within %0d cycles", nm, budget);
      end
   endtask

   typedef struct {
      string       name;
      logic [15:0] err_addr;
      int          err_n;
      bit          noresp;
      int          n_w0100;
      bit          exp_done;
      bit          exp_fail;
      logic [5:0]  exp_idx;
   } vec_t;

   initial begin
      vec_t vecs[4];
      int   st, drop, nw, n;

      vecs[0] = '{"normal", 16'hFFFF,  0, 1'b0, 1, 1'b1, 1'b0, 6'd0};
      vecs[1] = '{"err2",   16'h0100,  2, 1'b0, 3, 1'b1, 1'b0, 6'd0};
      vecs[2] = '{"errall", 16'h0100, -1, 1'b0, 3, 1'b0, 1'b1, 6'd2};
      vecs[3] = '{"noresp", 16'h0100,  0, 1'b1, 3, 1'b0, 1'b1, 6'd2};

      // reset state
      tick(3);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_fail", o_fail, 0);
      chk("rst_fail_idx", o_fail_idx, 0);
      chk("rst_cfg_start", o_cfg_start, 0);
      chk("rst_cfg_write", o_cfg_write, 0);
      chk("rst_cfg_read", o_cfg_read, 0);
      chk("rst_cfg_addr", o_cfg_addr, 0);
      chk("rst_cfg_wdata", o_cfg_wdata, 0);
      i_rst_n = 1'b1;
      tick(3);

      for (int v = 0; v < 4; v++) begin
         clear_model();
         err_addr = vecs[v].err_addr;
         err_left = vecs[v].err_n;
         noresp   = vecs[v].noresp;
         push_w(16'h0103, 1'b1);
         for (int k = 0; k < vecs[v].n_w0100; k++)
            push_w(16'h0100, vecs[v].exp_done && (k == vecs[v].n_w0100 - 1));
         st = cyc + 1;
         start_pulse();
         wait_end(vecs[v].name, 3000);
         tick(60);
         chk({vecs[v].name, "_done"}, o_done, vecs[v].exp_done);
         chk({vecs[v].name, "_fail"}, o_fail, vecs[v].exp_fail);
         chk({vecs[v].name, "_busy"}, o_busy, 0);
         if (vecs[v].exp_fail) chk({vecs[v].name, "_fail_idx"}, o_fail_idx, vecs[v].exp_idx);
         chk({vecs[v].name, "_missing_strobes"}, exp_q.size(), 0);
         n = stb_cyc.size();
         if (n > 0) chk({vecs[v].name, "_first_strobe_lat"}, stb_cyc[0] - st, 2);
         nw = VER ? 2 : 1;
         if (v == 0 && n > nw)
            chk("normal_delay_gap_ge_100", (stb_cyc[nw] - stb_cyc[0]) >= 100, 1);
         if (vecs[v].noresp && n >= 2)
            chk("noresp_retry_gap_100_105",
                (stb_cyc[n-1] - stb_cyc[n-2]) >= 100 && (stb_cyc[n-1] - stb_cyc[n-2]) <= 105, 1);
      end

      // cfg busy held 50 cycles, then a start pulse mid-run that must be ignored
      clear_model();
      push_normal();
      i_cfg_busy = 1'b1;
      start_pulse();
      tick(50);
      chk("busy_hold_no_strobe", stb_cyc.size(), 0);
      chk("busy_hold_o_busy", o_busy, 1);
      i_cfg_busy = 1'b0;
      drop = cyc;
      tick(60);
      start_pulse();
      wait_end("busy", 2000);
      tick(20);
      chk("busy_done", o_done, 1);
      chk("busy_missing_strobes", exp_q.size(), 0);
      if (stb_cyc.size() > 0) chk("busy_strobe_after_drop", stb_cyc[0] > drop, 1);

      // reset asserted during the delay, then a clean restart from index 0
      clear_model();
      push_normal();
      start_pulse();
      tick(60);
      i_rst_n = 1'b0;
      #1;
      chk("midrst_busy", o_busy, 0);
      chk("midrst_cfg_write", o_cfg_write, 0);
      chk("midrst_cfg_addr", o_cfg_addr, 0);
      chk("midrst_cfg_wdata", o_cfg_wdata, 0);
      chk("midrst_done", o_done, 0);
      tick(2);
      i_rst_n = 1'b1;
      tick(2);
      clear_model();
      push_normal();
      st = cyc + 1;
      start_pulse();
      wait_end("restart", 2000);
      tick(20);
      chk("restart_done", o_done, 1);
      chk("restart_missing_strobes", exp_q.size(), 0);
      if (stb_cyc.size() > 0) chk("restart_first_strobe_lat", stb_cyc[0] - st, 2);

`ifdef OV9281_INIT_VERIFY_EN
      // readback of 0x0100 returns 0x00 once: write reissued, second readback passes
      clear_model();
      bad_rd_once = 1'b1;
      push(1'b0, 16'h0103); push(1'b1, 16'h0103);
      push(1'b0, 16'h0100); push(1'b1, 16'h0100);
      push(1'b0, 16'h0100); push(1'b1, 16'h0100);
      start_pulse();
      wait_end("verify", 2000);
      tick(20);
      chk("verify_done", o_done, 1);
      chk("verify_fail", o_fail, 0);
      chk("verify_missing_strobes", exp_q.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
